booth_mult_arbiter: RTL and testbench



---
 rtl/booth_mult_arbiter.sv | 149 ++++++++++++++
 tb/tb_booth_mult_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_arbiter.sv
// Round-robin front end that shares one sequential Booth multiplier between two
// requesters, with a watchdog that completes a stuck operation with an error.
module booth_mult_arbiter #(
    parameter int L_word    = 4,
    parameter int L_TMO     = 7,
    parameter int TMO_LIMIT = 64
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  req_0,
    input  logic [L_word-1:0]     a_0,
    input  logic [L_word-1:0]     b_0,
    output logic                  gnt_0,
    output logic                  done_0,

    input  logic                  req_1,
    input  logic [L_word-1:0]     a_1,
    input  logic [L_word-1:0]     b_1,
    output logic                  gnt_1,
    output logic                  done_1,

    output logic [2*L_word-1:0]   result,
    output logic                  result_id,
    output logic                  result_err,
    output logic                  busy,
    output logic                  tmo_err,

    output logic [L_word-1:0]     mult_word1,
    output logic [L_word-1:0]     mult_word2,
    output logic                  mult_start,
    input  logic                  mult_ready,
    input  logic [2*L_word-1:0]   mult_product
);

    localparam int NREQ = 2;
    localparam logic [L_TMO-1:0] TMO_CNT = L_TMO'(TMO_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, LAUNCH, RUN} state_t;

    state_t                       state;
    logic                         owner;
    logic                         rr_last;
    logic [L_TMO-1:0]             wd;
    logic [L_TMO-1:0]             wd_next;
    logic [NREQ-1:0]              gnt_q;
    logic [NREQ-1:0]              done_q;

    logic [NREQ-1:0]              req_vec;
    logic [NREQ-1:0][L_word-1:0]  a_vec;
    logic [NREQ-1:0][L_word-1:0]  b_vec;
    logic                         pick_valid;
    logic                         pick;

    assign req_vec = {req_1, req_0};
    assign a_vec   = {a_1, a_0};
    assign b_vec   = {b_1, b_0};

    assign gnt_0   = gnt_q[0];
    assign gnt_1   = gnt_q[1];
    assign done_0  = done_q[0];
    assign done_1  = done_q[1];
    assign busy    = (state != IDLE);
    assign wd_next = wd + 1'b1;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick_valid = |req_vec;
        pick       = 1'b0;
        if (req_vec == 2'b11)
            pick = ~rr_last;
        else
            pick = req_vec[1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            rr_last    <= 1'b1;
            wd         <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            result     <= '0;
            result_id  <= 1'b0;
            result_err <= 1'b0;
            tmo_err    <= 1'b0;
            mult_word1 <= '0;
            mult_word2 <= '0;
            mult_start <= 1'b0;
        end else begin
            gnt_q      <= '0;
            done_q     <= '0;
            mult_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        mult_word1  <= a_vec[pick];
                        mult_word2  <= b_vec[pick];
                        owner       <= pick;
                        gnt_q[pick] <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    mult_start <= 1'b1;
                    wd         <= '0;
                    state      <= LAUNCH;
                end
                LAUNCH: begin
                    // Ready may still be high from the previous product; wait for it to drop.
                    wd <= wd_next;
                    if (wd_next == TMO_CNT) begin
                        result        <= '0;
                        result_id     <= owner;
                        result_err    <= 1'b1;
                        tmo_err       <= 1'b1;
                        done_q[owner] <= 1'b1;
                        rr_last       <= owner;
                        state         <= IDLE;
                    end else if (!mult_ready) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    wd <= wd_next;
                    if (mult_ready) begin
                        result        <= mult_product;
                        result_id     <= owner;
                        result_err    <= 1'b0;
                        done_q[owner] <= 1'b1;
                        rr_last       <= owner;
                        state         <= IDLE;
                    end else if (wd_next == TMO_CNT) begin
                        result        <= '0;
                        result_id     <= owner;
                        result_err    <= 1'b1;
                        tmo_err       <= 1'b1;
                        done_q[owner] <= 1'b1;
                        rr_last       <= owner;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Scoreboard bench for booth_mult_arbiter with a behavioural multiplier whose
// Ready stays high after completion until the next Start.
module tb_booth_mult_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_0 = 1'b0, req_1 = 1'b0;
    logic [3:0] a_0 = '0, b_0 = '0, a_1 = '0, b_1 = '0;
    logic       gnt_0, done_0, gnt_1, done_1;
    logic [7:0] result;
    logic       result_id, result_err, busy, tmo_err;
    logic [3:0] mult_word1, mult_word2;
    logic       mult_start, mult_ready;
    logic [7:0] mult_product;

    booth_mult_arbiter #(.L_word(4), .L_TMO(7), .TMO_LIMIT(64)) dut (
        .clock(clock), .reset(reset),
        .req_0(req_0), .a_0(a_0), .b_0(b_0), .gnt_0(gnt_0), .done_0(done_0),
        .req_1(req_1), .a_1(a_1), .b_1(b_1), .gnt_1(gnt_1), .done_1(done_1),
        .result(result), .result_id(result_id), .result_err(result_err),
        .busy(busy), .tmo_err(tmo_err),
        .mult_word1(mult_word1), .mult_word2(mult_word2), .mult_start(mult_start),
        .mult_ready(mult_ready), .mult_product(mult_product)
    );

    always #5 clock = ~clock;

    // Multiplier model: latency mlat edges after Start, force_nready masks Ready.
    int         mlat = 4;
    logic       force_nready = 1'b0;
    logic       m_rdy;
    logic [7:0] m_prod, m_pend;
    int         m_cnt;
    always @(posedge clock) begin
        if (reset) begin
            m_rdy <= 1'b0; m_prod <= '0; m_pend <= '0; m_cnt <= 0;
        end else if (mult_start) begin
            m_rdy  <= 1'b0;
            m_cnt  <= mlat;
            m_pend <= 8'($signed({{4{mult_word1[3]}}, mult_word1}) *
                         $signed({{4{mult_word2[3]}}, mult_word2}));
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_rdy  <= 1'b1;
                m_prod <= m_pend;
            end
        end
    end
    assign mult_ready   = m_rdy & ~force_nready;
    assign mult_product = m_prod;

    int checks = 0, failures = 0, cyc = 0, dones = 0, t_done = 0;

    typedef struct {
        logic       id;
        logic [7:0] res;
        logic       err;
    } exp_t;
    exp_t sb[$];
    logic gq[$];

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: grants and completions are checked against the queues as they appear.
    always @(negedge clock) begin : mon
        logic g;
        exp_t e;
        if (!reset) begin
            if (gnt_0 || gnt_1) begin
                if (gq.size() == 0) chk("gnt_unexpected", 32'({gnt_1, gnt_0}), 32'd0);
                else begin
                    g = gq.pop_front();
                    chk("gnt_order", 32'({gnt_1, gnt_0}), g ? 32'd2 : 32'd1);
                end
            end
            if (done_0 || done_1) begin
                dones++;
                t_done = cyc;
                if (sb.size() == 0) chk("done_unexpected", 32'({done_1, done_0}), 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("done_owner", 32'({done_1, done_0}), e.id ? 32'd2 : 32'd1);
                    chk("result_id", 32'(result_id), 32'(e.id));
                    chk("result", 32'(result), 32'(e.res));
                    chk("result_err", 32'(result_err), 32'(e.err));
                end
            end
        end
    end

    task automatic chk_reset_state();
        chk("rst_ctrl", 32'({gnt_0, gnt_1, done_0, done_1, busy, tmo_err, mult_start, result_err, result_id}), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_words", 32'({mult_word1, mult_word2}), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
        gq.delete();
        @(negedge clock);
    endtask

    // Issue one request, check the grant/start handshake, wait for completion.
    task automatic run_op(input logic id, input logic [3:0] a, input logic [3:0] b, input int lat,
                          input logic [7:0] exp_res, input logic exp_err, output int latency);
        logic got;
        int   t_gnt;
        mlat  = lat;
        sb.push_back(exp_t'{id: id, res: exp_res, err: exp_err});
        gq.push_back(id);
        if (id) begin req_1 = 1'b1; a_1 = a; b_1 = b; end
        else    begin req_0 = 1'b1; a_0 = a; b_0 = b; end
        got   = 1'b0;
        t_gnt = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            got = id ? gnt_1 : gnt_0;
        end
        t_gnt = cyc;
        req_0 = 1'b0;
        req_1 = 1'b0;
        chk("gnt_seen", 32'(got), 32'd1);
        if (got) begin
            chk("busy_at_gnt", 32'(busy), 32'd1);
            chk("word1", 32'(mult_word1), 32'(a));
            chk("word2", 32'(mult_word2), 32'(b));
            chk("start_before", 32'(mult_start), 32'd0);
            @(negedge clock);
            chk("start_pulse", 32'(mult_start), 32'd1);
            @(negedge clock);
            chk("start_one_cycle", 32'(mult_start), 32'd0);
        end
        drain();
        latency = t_done - t_gnt;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int lat;
        int d0;
        logic got;

        repeat (3) @(negedge clock);
        chk_reset_state();
        reset = 1'b0;
        @(negedge clock);

        // Basic operations; 1 cycle gnt->start, 4-edge multiplier, done 1 after Ready.
        run_op(1'b0, 4'd3, 4'd5, 4, 8'h0F, 1'b0, lat);
        chk("latency_first", 32'(lat), 32'd7);
        run_op(1'b1, 4'hD, 4'd5, 5, 8'hF1, 1'b0, lat);
        run_op(1'b1, 4'h8, 4'h8, 8, 8'h40, 1'b0, lat);

        // Both requesting and held: 0 then 1, never 0 twice.
        mlat = 6;
        gq.push_back(1'b0); gq.push_back(1'b1);
        sb.push_back(exp_t'{id: 1'b0, res: 8'h06, err: 1'b0});
        sb.push_back(exp_t'{id: 1'b1, res: 8'hF9, err: 1'b0});
        req_0 = 1'b1; a_0 = 4'd2; b_0 = 4'd3;
        req_1 = 1'b1; a_1 = 4'd7; b_1 = 4'hF;
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clock);
            got = gnt_1;
        end
        req_0 = 1'b0;
        req_1 = 1'b0;
        chk("both_gnt1_seen", 32'(got), 32'd1);
        drain();

        // Stale Ready from the previous product must not be taken as completion.
        chk("stale_ready_present", 32'(mult_ready), 32'd1);
        run_op(1'b0, 4'hE, 4'd3, 8, 8'hFA, 1'b0, lat);
        chk("latency_stale", 32'(lat), 32'd11);

        // Watchdog: 64 cycles in LAUNCH+RUN, done lands 65 cycles after gnt.
        force_nready = 1'b1;
        run_op(1'b0, 4'd1, 4'd1, 4, 8'h00, 1'b1, lat);
        chk("latency_timeout", 32'(lat), 32'd65);
        chk("tmo_err_set", 32'(tmo_err), 32'd1);
        force_nready = 1'b0;
        run_op(1'b1, 4'hF, 4'hF, 4, 8'h01, 1'b0, lat);
        chk("tmo_err_sticky", 32'(tmo_err), 32'd1);

        // Reset mid-operation aborts without a done pulse.
        mlat = 8;
        gq.push_back(1'b0);
        req_0 = 1'b1; a_0 = 4'd3; b_0 = 4'd3;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            got = gnt_0;
        end
        req_0 = 1'b0;
        chk("abort_gnt_seen", 32'(got), 32'd1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk_reset_state();
        d0 = dones;
        reset = 1'b0;
        repeat (20) @(negedge clock);
        chk("no_done_after_abort", 32'(dones), 32'(d0));
        gq.delete();

        run_op(1'b1, 4'd7, 4'd7, 4, 8'h31, 1'b0, lat);
        chk("latency_after_reset", 32'(lat), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
